// File: rtl/pe_start_token_fifo.sv
// Start-token FIFO feeding a PE: shift-register storage read through a pointer.
// Define PE_START_FIFO_OCC_EN to add the occupancy and overflow-error outputs.
module pe_start_token_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  if_full_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout
`ifdef PE_START_FIFO_OCC_EN
  ,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_overflow_err
`endif
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned SLOTS = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] srl_q [SLOTS];
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  full_n_q, full_n_d;
  logic                  empty_n_q, empty_n_d;
  logic                  wr_ok, rd_ok;

  assign wr_ok = if_write & full_n_q;
  assign rd_ok = if_read & empty_n_q;

  // Token storage: newest at index 0, not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 1; i < int'(DEPTH); i++) begin
        srl_q[i] <= srl_q[i-1];
      end
      srl_q[0] <= if_din;
    end
  end

  // Pointer and flag next-state; ptr all-ones means empty.
  always_comb begin
    ptr_d     = ptr_q;
    full_n_d  = full_n_q;
    empty_n_d = empty_n_q;
    if (wr_ok && !rd_ok) begin
      ptr_d     = ptr_q + PTR_W'(1);
      empty_n_d = 1'b1;
      full_n_d  = (ptr_d != PTR_W'(DEPTH - 1));
    end else if (rd_ok && !wr_ok) begin
      ptr_d     = ptr_q - PTR_W'(1);
      full_n_d  = 1'b1;
      empty_n_d = (ptr_d != {PTR_W{1'b1}});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q     <= {PTR_W{1'b1}};
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign if_dout    = srl_q[ptr_q[ADDR_WIDTH-1:0]];

`ifdef PE_START_FIFO_OCC_EN
  logic ovf_q, ovf_d;

  // Sticky: any request made against a deasserted flag.
  always_comb begin
    ovf_d = ovf_q;
    if ((if_write && !full_n_q) || (if_read && !empty_n_q)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign if_num_data_valid = ptr_q + PTR_W'(1);
  assign if_overflow_err   = ovf_q;
`endif

endmodule
